mix_column_seq: RTL

//  Sequential, parametrised AES MixColumns engine for the 128-bit round datapath.

---
 rtl/aes_mix_pkg.sv | 61 ++++++
 rtl/mix_col_word.sv | 46 ++++
 rtl/mix_column_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/aes_mix_pkg.sv
// aes_mix_pkg: shared types and GF(2^8) helpers for the MixColumns engine.
//   COL_W / STATE_W / NCOLS : column width, state width, columns per state
//   col_t                   : one 32-bit column, row 0 in the MSB byte
//   mix_state_t             : engine FSM encoding
//   xtime, gf_mul2/3/9/b/d/e: constant multipliers modulo x^8+x^4+x^3+x+1
package aes_mix_pkg;

    localparam int COL_W   = 32;
    localparam int STATE_W = 128;
    localparam int NCOLS   = STATE_W / COL_W;

    typedef logic [COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Inverse coefficients are built from x*2, x*4, x*8 partial products.
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] x);
        logic [7:0] x2, x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] x);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// mix_col_word: combinational MixColumns of a single 32-bit column.
//   col_in  : input column, row 0 = MSB byte
//   inv     : 1 selects InvMixColumns (only when INV_MIX_EN is defined)
//   col_out : transformed column, same byte order
// Macro INV_MIX_EN builds the inverse datapath; without it only the
// forward matrix exists and inv is ignored.
module mix_col_word
    import aes_mix_pkg::*;
(
    input  col_t col_in,
    input  logic inv,
    output col_t col_out
);

    // bytes[3] is row 0 so row r lives at index 3-r
    logic [3:0][7:0] bytes;
    logic [3:0][7:0] fwd;

    assign bytes = col_in;

    // Circulant matrix: row r uses {2,3,1,1} rotated right by r.
    for (genvar r = 0; r < 4; r++) begin : g_fwd
        assign fwd[3-r] = gf_mul2(bytes[3-r])
                        ^ gf_mul3(bytes[3-((r+1)%4)])
                        ^ bytes[3-((r+2)%4)]
                        ^ bytes[3-((r+3)%4)];
    end

`ifdef INV_MIX_EN
    logic [3:0][7:0] rev;

    for (genvar r = 0; r < 4; r++) begin : g_inv
        assign rev[3-r] = gf_mule(bytes[3-r])
                        ^ gf_mulb(bytes[3-((r+1)%4)])
                        ^ gf_muld(bytes[3-((r+2)%4)])
                        ^ gf_mul9(bytes[3-((r+3)%4)]);
    end

    assign col_out = inv ? col_t'(rev) : col_t'(fwd);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign col_out    = col_t'(fwd);
`endif

endmodule

// File: rtl/mix_column_seq.sv
// mix_column_seq: sequential AES MixColumns engine, transforms the state in
// place COLS_PER_CYCLE columns per clock and holds the result on a
// valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data is the 128-bit state
//                         (column c = [127-32c -: 32], row 0 = MSB byte)
//   in_inv              : 1 = InvMixColumns, sampled at accept
//   out_valid/out_ready : output handshake, out_data held until consumed
//   busy                : high while columns are being transformed
// Macro INV_MIX_EN enables the inverse datapath; otherwise in_inv is ignored.
module mix_column_seq
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int NCYC = NCOLS / COLS_PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mix_state_t             state;
    logic [CW-1:0]          col_cnt;
    col_t [NCOLS-1:0]       data_q;     // index NCOLS-1 holds column 0
    col_t [NCOLS-1:0]       data_nxt;
    logic                   inv_q;
    logic                   accept;

    col_t [COLS_PER_CYCLE-1:0]       col_in;
    col_t [COLS_PER_CYCLE-1:0]       col_out;
    logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;

    assign in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // Lane g works on column col_cnt*COLS_PER_CYCLE + g.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_idx[g] = 2'((int'(col_cnt) * COLS_PER_CYCLE) + g);
        assign col_in[g]  = data_q[2'd3 - col_idx[g]];

        mix_col_word u_word (
            .col_in  (col_in[g]),
            .inv     (inv_q),
            .col_out (col_out[g])
        );
    end

    always_comb begin
        data_nxt = data_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++)
            data_nxt[2'd3 - col_idx[g]] = col_out[g];
    end

`ifdef INV_MIX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (accept)
            inv_q <= in_inv;
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_q         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col_cnt   <= '0;
            data_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_BUSY;
                        busy    <= 1'b1;
                        data_q  <= in_data;
                        col_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    data_q  <= data_nxt;
                    col_cnt <= col_cnt + 1'b1;
                    if (col_cnt == CW'(NCYC - 1)) begin
                        // Result becomes visible only once every column is done.
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= data_nxt;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Consume and reload in the same cycle.
                            state   <= ST_BUSY;
                            busy    <= 1'b1;
                            data_q  <= in_data;
                            col_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
